// File: rtl/toy_pkg.sv
// ---------------------------------------------------------------------------
// toy_pkg
//   Shared constants for the toy MCU serial blocks: clock/baud defaults, the
//   UART frame width and the receive FSM state encoding.
// ---------------------------------------------------------------------------
package toy_pkg;

  // Board clock and line rate; the receiver's bit period is derived from these.
  localparam int CLK_FREQ_HZ      = 25_000_000;
  localparam int UART_BAUD_RATE   = 9600;
  localparam int DEFAULT_BAUD_DIV = CLK_FREQ_HZ / UART_BAUD_RATE;  // 2604

  localparam int UART_DATA_BITS   = 8;

  // Receive FSM encoding, kept as plain constants for legacy tools.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

endpackage : toy_pkg

// File: rtl/toy_baud_counter.sv
// ---------------------------------------------------------------------------
// toy_baud_counter
//   Bit-period counter shared by the UART receiver and transmitter. Counts
//   0..BAUD_DIV-1 while enabled and wraps; i_clr forces it back to 0.
//
// Ports
//   i_clk        in  1  system clock
//   i_rst        in  1  synchronous active-high reset
//   i_clr        in  1  restart the bit period (priority over i_en)
//   i_en         in  1  advance the counter this cycle
//   o_tick_half  out 1  enabled and count == BAUD_DIV/2-1 (mid-bit point)
//   o_tick_full  out 1  enabled and count == BAUD_DIV-1 (end of bit period)
// ---------------------------------------------------------------------------
module toy_baud_counter
  import toy_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick_half,
  output logic o_tick_full
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

  logic [CW-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      if (r_count == FULL_M1) r_count <= '0;
      else                    r_count <= r_count + 1'b1;
    end
  end

  assign o_tick_half = i_en && (r_count == HALF_M1);
  assign o_tick_full = i_en && (r_count == FULL_M1);

endmodule : toy_baud_counter

// File: rtl/toy_uart_rx.sv
// ---------------------------------------------------------------------------
// toy_uart_rx
//   8N1 UART receiver. Recovers bytes from the asynchronous serial pin and
//   presents them on a valid/ready handshake with framing-error and overrun
//   pulses.
//
// Ports
//   i_clk        in  1  system clock, all logic on posedge
//   i_rst        in  1  synchronous active-high reset
//   i_uart_rx    in  1  serial line, idle high, asynchronous to i_clk
//   o_data       out 8  received byte, stable while o_valid=1
//   o_valid      out 1  byte available, held until accepted
//   i_ready      in  1  consumer takes the byte when o_valid & i_ready
//   o_frame_err  out 1  one-cycle pulse: stop bit sampled low
//   o_overrun    out 1  one-cycle pulse: new byte dropped, old one not taken
// ---------------------------------------------------------------------------
module toy_uart_rx
  import toy_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_uart_rx,
  output logic [UART_DATA_BITS-1:0] o_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_frame_err,
  output logic                      o_overrun
);

  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [IW-1:0] LAST_BIT = IW'(UART_DATA_BITS - 1);

  logic                      r_rx_meta;
  logic                      r_rx_s;
  logic [2:0]                r_state;
  logic [IW-1:0]             r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] r_data;
  logic                      r_valid;
  logic                      r_frame_err;
  logic                      r_overrun;

  logic w_tick_half;
  logic w_tick_full;
  logic w_baud_en;
  logic w_baud_clr;
  logic w_stop_sample;
  logic w_byte_done;
  logic w_frame_bad;

  // Two-flop synchroniser; resets to the idle-high line level so leaving
  // reset never looks like a start bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_uart_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // The counter is held at 0 in IDLE so START measures half a bit from the
  // detected edge, and restarted at mid start bit so every later full tick
  // lands in the middle of a bit.
  assign w_baud_en  = (r_state == ST_START) || (r_state == ST_DATA) ||
                      (r_state == ST_STOP);
  assign w_baud_clr = (r_state == ST_IDLE) ||
                      ((r_state == ST_START) && w_tick_half);

  toy_baud_counter #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clr       (w_baud_clr),
    .i_en        (w_baud_en),
    .o_tick_half (w_tick_half),
    .o_tick_full (w_tick_full)
  );

  assign w_stop_sample = (r_state == ST_STOP) && w_tick_full;
  assign w_byte_done   = w_stop_sample &&  r_rx_s;
  assign w_frame_bad   = w_stop_sample && !r_rx_s;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      // NOTE: every case arm is in a clocked block and the default recovers
      // unused encodings, so no state can hang and no latch can form.
      case (r_state)
        ST_IDLE: begin
          if (!r_rx_s) r_state <= ST_START;
        end
        ST_START: begin
          if (w_tick_half) begin
            if (r_rx_s) begin
              r_state <= ST_IDLE;  // line went back high: glitch, not a start
            end else begin
              r_state   <= ST_DATA;
              r_bit_idx <= '0;
            end
          end
        end
        ST_DATA: begin
          if (w_tick_full) begin
            r_shift   <= {r_rx_s, r_shift[UART_DATA_BITS-1:1]};  // LSB first
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == LAST_BIT) r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_tick_full) r_state <= r_rx_s ? ST_IDLE : ST_WAIT_IDLE;
        end
        ST_WAIT_IDLE: begin
          // Hold off through a break until the line is idle again.
          if (r_rx_s) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output side: a completed byte loads if the holding register is empty or
  // being emptied this same cycle; otherwise it is dropped and flagged.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_bad;
      r_overrun   <= 1'b0;
      if (w_byte_done) begin
        if (!r_valid || i_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;

endmodule : toy_uart_rx

// File: tb/tb_toy_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_toy_uart_rx
//   Directed bench for toy_uart_rx with BAUD_DIV=16. A bit-banged driver
//   sends frames on the serial pin; a negedge monitor logs accepted bytes
//   and counts valid cycles and flag pulses, and the main sequence compares
//   the changes in those logs against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_toy_uart_rx;

  localparam int BIT = 16;

  logic       i_clk     = 1'b0;
  logic       i_rst     = 1'b1;
  logic       i_uart_rx = 1'b1;
  logic       i_ready   = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;

  always #5 i_clk = ~i_clk;

  toy_uart_rx #(
    .BAUD_DIV (BIT)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_uart_rx   (i_uart_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun)
  );

  // Monitor: sampled mid-cycle, when inputs and outputs are both settled.
  int         mon_valid_cycles = 0;
  int         mon_ferr         = 0;
  int         mon_ovr          = 0;
  logic [7:0] rx_q[$];

  always @(negedge i_clk) begin
    if (o_valid)            mon_valid_cycles++;
    if (o_frame_err)        mon_ferr++;
    if (o_overrun)          mon_ovr++;
    if (o_valid && i_ready) rx_q.push_back(o_data);
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int b_v, b_f, b_o, b_q;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks and land just after the rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int cycles);
    i_uart_rx = b;
    step(cycles);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_val,
                            input int stop_bits);
    send_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) send_bit(d[i], BIT);
    send_bit(stop_val, stop_bits * BIT);
    i_uart_rx = 1'b1;
  endtask

  task automatic snap();
    b_v = mon_valid_cycles;
    b_f = mon_ferr;
    b_o = mon_ovr;
    b_q = rx_q.size();
  endtask

  function automatic logic [31:0] q_at(input int idx);
    if (idx < rx_q.size()) return 32'(rx_q[idx]);
    return 32'hDEAD;
  endfunction

  initial begin
    // Reset state
    step(4);
    check("rst_data",  32'(o_data),      32'h00);
    check("rst_valid", 32'(o_valid),     32'h0);
    check("rst_ferr",  32'(o_frame_err), 32'h0);
    check("rst_ovr",   32'(o_overrun),   32'h0);
    i_rst   = 1'b0;
    i_ready = 1'b1;
    step(5);
    check("idle_valid", 32'(o_valid), 32'h0);

    // 1: single byte, consumer ready
    snap();
    send_frame(8'hA5, 1'b1, 1);
    step(8);
    check("a5_count",  32'(rx_q.size() - b_q),      32'd1);
    check("a5_data",   q_at(b_q),                   32'hA5);
    check("a5_vcyc",   32'(mon_valid_cycles - b_v), 32'd1);
    check("a5_ferr",   32'(mon_ferr - b_f),         32'd0);
    check("a5_ovr",    32'(mon_ovr - b_o),          32'd0);

    // 2: short low glitch is rejected, next frame still received
    snap();
    send_bit(1'b0, 3);
    send_bit(1'b1, 2 * BIT);
    check("glitch_vcyc", 32'(mon_valid_cycles - b_v), 32'd0);
    check("glitch_ferr", 32'(mon_ferr - b_f),         32'd0);
    send_frame(8'h3C, 1'b1, 1);
    step(8);
    check("3c_count", 32'(rx_q.size() - b_q), 32'd1);
    check("3c_data",  q_at(b_q),              32'h3C);

    // 3: stop bit held low for two bits, then recovery
    snap();
    send_frame(8'h55, 1'b0, 2);
    step(2 * BIT);
    check("brk_ferr", 32'(mon_ferr - b_f),         32'd1);
    check("brk_vcyc", 32'(mon_valid_cycles - b_v), 32'd0);
    check("brk_ovr",  32'(mon_ovr - b_o),          32'd0);
    snap();
    send_frame(8'h01, 1'b1, 1);
    step(8);
    check("01_count", 32'(rx_q.size() - b_q), 32'd1);
    check("01_data",  q_at(b_q),              32'h01);
    check("01_ferr",  32'(mon_ferr - b_f),    32'd0);

    // 4: overrun while the consumer stalls
    i_ready = 1'b0;
    step(2);
    snap();
    send_frame(8'h11, 1'b1, 1);
    step(4);
    send_frame(8'h22, 1'b1, 1);
    step(8);
    check("ovr_valid", 32'(o_valid),             32'h1);
    check("ovr_data",  32'(o_data),              32'h11);
    check("ovr_pulse", 32'(mon_ovr - b_o),       32'd1);
    check("ovr_noacc", 32'(rx_q.size() - b_q),   32'd0);
    check("ovr_ferr",  32'(mon_ferr - b_f),      32'd0);
    i_ready = 1'b1;
    step(3);
    check("ovr_drop",  32'(o_valid),             32'h0);
    check("ovr_taken", 32'(rx_q.size() - b_q),   32'd1);
    check("ovr_tdata", q_at(b_q),                32'h11);

    // 5: back-to-back frames
    step(2 * BIT);
    snap();
    send_frame(8'h00, 1'b1, 1);
    send_frame(8'hFF, 1'b1, 1);
    step(8);
    check("b2b_count", 32'(rx_q.size() - b_q),      32'd2);
    check("b2b_first", q_at(b_q),                   32'h00);
    check("b2b_second", q_at(b_q + 1),              32'hFF);
    check("b2b_vcyc",  32'(mon_valid_cycles - b_v), 32'd2);
    check("b2b_flags", 32'((mon_ferr - b_f) + (mon_ovr - b_o)), 32'd0);

    // 6: reset in the middle of data bit 4 of 0x5A
    step(2 * BIT);
    snap();
    send_bit(1'b0, BIT);
    send_bit(1'b0, BIT);  // bit0
    send_bit(1'b1, BIT);  // bit1
    send_bit(1'b0, BIT);  // bit2
    send_bit(1'b1, BIT);  // bit3
    send_bit(1'b1, BIT / 2);  // half of bit4
    i_rst     = 1'b1;
    i_uart_rx = 1'b1;
    step(3);
    check("mrst_data",  32'(o_data),      32'h00);
    check("mrst_valid", 32'(o_valid),     32'h0);
    check("mrst_ferr",  32'(o_frame_err), 32'h0);
    check("mrst_ovr",   32'(o_overrun),   32'h0);
    i_rst = 1'b0;
    step(3 * BIT);
    check("mrst_none", 32'(rx_q.size() - b_q), 32'd0);
    send_frame(8'h77, 1'b1, 1);
    step(8);
    check("77_count", 32'(rx_q.size() - b_q),      32'd1);
    check("77_data",  q_at(b_q),                   32'h77);
    check("77_vcyc",  32'(mon_valid_cycles - b_v), 32'd1);
    check("77_flags", 32'((mon_ferr - b_f) + (mon_ovr - b_o)), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_toy_uart_rx
